// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg: shared types for the commit trace checker.
//   - record type enum, packed commit record {type, A, B}
//   - checker state enum and field width constants
// Optional feature macro used by the checker: COMMIT_CHK_LOAD_EN
package commit_trace_pkg;

   localparam int unsigned TYPE_W  = 2;
   localparam int unsigned FIELD_W = 16;
   localparam int unsigned REG_W   = 3;
   localparam int unsigned REC_W   = TYPE_W + 2 * FIELD_W;

   typedef enum logic [TYPE_W-1:0] {
      REC_REG   = 2'd0,
      REC_LOAD  = 2'd1,
      REC_STORE = 2'd2,
      REC_HALT  = 2'd3
   } recType_e;

   typedef struct packed {
      recType_e             recType;
      logic [FIELD_W-1:0]   fieldA;
      logic [FIELD_W-1:0]   fieldB;
   } commitRec_t;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_DONE     = 2'd1,
      ST_MISMATCH = 2'd2,
      ST_ERROR    = 2'd3
   } chkState_e;

   function automatic commitRec_t mkRec(input recType_e t, input logic [FIELD_W-1:0] a,
                                        input logic [FIELD_W-1:0] b);
      commitRec_t r;
      r.recType = t;
      r.fieldA  = a;
      r.fieldB  = b;
      return r;
   endfunction

endpackage

// File: rtl/commit_trace_checker_if.sv
// commit_trace_checker_if: processor commit activity plus the expected-record
// stream handshake.
//   master: drives commit signals and expected records, receives exp_ready
//   slave : the checker
interface commit_trace_checker_if;
   import commit_trace_pkg::*;

   logic                 reg_write;
   logic [REG_W-1:0]     write_reg;
   logic [FIELD_W-1:0]   write_data;
   logic                 mem_read;
   logic                 mem_write;
   logic [FIELD_W-1:0]   mem_addr;
   logic [FIELD_W-1:0]   mem_data_in;
   logic [FIELD_W-1:0]   mem_data_out;
   logic                 halt;
   logic                 exp_valid;
   logic [TYPE_W-1:0]    exp_type;
   logic [FIELD_W-1:0]   exp_a;
   logic [FIELD_W-1:0]   exp_b;
   logic                 exp_ready;

   modport master (
      output reg_write, write_reg, write_data, mem_read, mem_write, mem_addr,
             mem_data_in, mem_data_out, halt, exp_valid, exp_type, exp_a, exp_b,
      input  exp_ready
   );

   modport slave (
      input  reg_write, write_reg, write_data, mem_read, mem_write, mem_addr,
             mem_data_in, mem_data_out, halt, exp_valid, exp_type, exp_a, exp_b,
      output exp_ready
   );

endinterface

// File: rtl/commit_fifo_mw.sv
// commit_fifo_mw: 3-write / 1-read record FIFO.
//   pushCnt       : number of wrData slots (from index 0) written this cycle
//   wrData        : up to three compacted records
//   pop           : consume head (caller guarantees non-empty)
//   head_c        : current head record
//   count_c       : occupancy
//   overflowRej_c : this cycle's pushes would exceed DEPTH; none are written
module commit_fifo_mw
   import commit_trace_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              pushCnt,
   input  commitRec_t [2:0]        wrData,
   input  logic                    pop,
   output commitRec_t              head_c,
   output logic [$clog2(DEPTH):0]  count_c,
   output logic                    overflowRej_c
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;
   localparam int unsigned SUM_W = PTR_W + 1;

   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   commitRec_t       mem [DEPTH];
   logic [SUM_W-1:0] nextOcc_c;

   // Pointers carry one extra bit so full and empty are distinguishable.
   assign count_c       = wrPtr - rdPtr;
   assign head_c        = mem[rdPtr[IDX_W-1:0]];
   assign nextOcc_c     = SUM_W'(count_c) + SUM_W'(pushCnt) - SUM_W'(pop);
   assign overflowRej_c = nextOcc_c > SUM_W'(DEPTH);

   // Storage and pointers; a rejected cycle still pops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[IDX_W'(i)] <= '0;
      end else begin
         if (pop) rdPtr <= rdPtr + PTR_W'(1);
         if (!overflowRej_c) begin
            for (int unsigned i = 0; i < 3; i++) begin
               if (i < 32'(pushCnt)) mem[IDX_W'(wrPtr + PTR_W'(i))] <= wrData[2'(i)];
            end
            wrPtr <= wrPtr + PTR_W'(pushCnt);
         end
      end
   end

endmodule

// File: rtl/commit_trace_checker.sv
// commit_trace_checker: turns per-cycle commit activity into ordered trace
// records (REG, memory, HALT), buffers them, and compares them one by one
// against an expected-record stream.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : commit activity + expected stream (slave modport)
//   done      : HALT record matched
//   mismatch  : first compare failure seen (sticky)
//   overflow  : record FIFO overflow seen (sticky)
//   rec_count : matched records (saturating)
//   err_index : 0-based index of the failing record
//   err_exp   : failing expected record {type, A, B}
//   err_act   : failing actual record {type, A, B}
// Macro COMMIT_CHK_LOAD_EN: when defined, LOAD records are generated.
module commit_trace_checker
   import commit_trace_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   commit_trace_checker_if.slave bus,
   output logic                  done,
   output logic                  mismatch,
   output logic                  overflow,
   output logic [CNT_W-1:0]      rec_count,
   output logic [CNT_W-1:0]      err_index,
   output logic [REC_W-1:0]      err_exp,
   output logic [REC_W-1:0]      err_act
);

   chkState_e               stateQ;
   chkState_e               stateD;
   logic                    haltPushedQ;
   logic                    captureEn_c;
   logic                    regV_c;
   logic                    memV_c;
   logic                    haltV_c;
   commitRec_t              regRec_c;
   commitRec_t              memRec_c;
   commitRec_t              haltRec_c;
   commitRec_t              headRec_c;
   commitRec_t              expRec_c;
   commitRec_t [2:0]        wrData_c;
   logic [1:0]              pushCnt_c;
   logic [$clog2(DEPTH):0]  fifoCount_c;
   logic                    overflowRej_c;
   logic                    handshake_c;
   logic                    recEq_c;

   // Capture runs until a HALT record has been pushed or a terminal state.
   assign captureEn_c = (stateQ == ST_RUN) && !haltPushedQ;
   assign regV_c      = captureEn_c && bus.reg_write;
   assign haltV_c     = captureEn_c && bus.halt;
   assign regRec_c    = mkRec(REC_REG, FIELD_W'(bus.write_reg), bus.write_data);
   assign haltRec_c   = mkRec(REC_HALT, '0, '0);

   // Memory record; a store wins over a simultaneous load.
`ifdef COMMIT_CHK_LOAD_EN
   assign memV_c   = captureEn_c && (bus.mem_write || bus.mem_read);
   assign memRec_c = bus.mem_write ? mkRec(REC_STORE, bus.mem_addr, bus.mem_data_in)
                                   : mkRec(REC_LOAD, bus.mem_addr, bus.mem_data_out);
`else
   logic unusedLoad;
   assign unusedLoad = ^{bus.mem_read, bus.mem_data_out};
   assign memV_c     = captureEn_c && bus.mem_write;
   assign memRec_c   = mkRec(REC_STORE, bus.mem_addr, bus.mem_data_in);
`endif

   // Compact this cycle's records in REG, memory, HALT order.
   always_comb begin
      wrData_c  = '0;
      pushCnt_c = '0;
      if (regV_c) begin
         wrData_c[pushCnt_c] = regRec_c;
         pushCnt_c           = pushCnt_c + 2'd1;
      end
      if (memV_c) begin
         wrData_c[pushCnt_c] = memRec_c;
         pushCnt_c           = pushCnt_c + 2'd1;
      end
      if (haltV_c) begin
         wrData_c[pushCnt_c] = haltRec_c;
         pushCnt_c           = pushCnt_c + 2'd1;
      end
   end

   commit_fifo_mw #(.DEPTH(DEPTH)) uFifo (
      .clk           (clk),
      .rst           (rst),
      .pushCnt       (pushCnt_c),
      .wrData        (wrData_c),
      .pop           (handshake_c),
      .head_c        (headRec_c),
      .count_c       (fifoCount_c),
      .overflowRej_c (overflowRej_c)
   );

   assign expRec_c      = mkRec(recType_e'(bus.exp_type), bus.exp_a, bus.exp_b);
   assign handshake_c   = (stateQ == ST_RUN) && (fifoCount_c != '0) && bus.exp_valid;
   assign recEq_c       = (headRec_c == expRec_c);
   assign bus.exp_ready = handshake_c;

   // Next state; overflow overrides any verdict reached in the same cycle.
   always_comb begin
      stateD = stateQ;
      if (handshake_c) begin
         if (!recEq_c)                          stateD = ST_MISMATCH;
         else if (headRec_c.recType == REC_HALT) stateD = ST_DONE;
      end
      if (overflowRej_c) stateD = ST_ERROR;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stateQ <= ST_RUN;
      else     stateQ <= stateD;
   end

   // Status and error capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         haltPushedQ <= 1'b0;
         done        <= 1'b0;
         mismatch    <= 1'b0;
         overflow    <= 1'b0;
         rec_count   <= '0;
         err_index   <= '0;
         err_exp     <= '0;
         err_act     <= '0;
      end else begin
         if (haltV_c)       haltPushedQ <= 1'b1;
         if (overflowRej_c) overflow    <= 1'b1;
         if (handshake_c) begin
            if (recEq_c) begin
               if (rec_count != '1) rec_count <= rec_count + CNT_W'(1);
               if (headRec_c.recType == REC_HALT) done <= 1'b1;
            end else begin
               mismatch  <= 1'b1;
               err_index <= rec_count;
               err_exp   <= expRec_c;
               err_act   <= headRec_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_commit_trace_checker.sv
// tb_commit_trace_checker: table-driven and sequence tests for
// commit_trace_checker with a queue of expected records.
// Honours COMMIT_CHK_LOAD_EN the same way as the design.
module tb_commit_trace_checker;
   import commit_trace_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned CNT_W = 32;

   typedef struct packed {
      logic                regW;
      logic [2:0]          wreg;
      logic [15:0]         wdata;
      logic                memW;
      logic                memR;
      logic [15:0]         addr;
      logic [15:0]         din;
      logic [15:0]         dout;
      logic                hlt;
      logic [1:0]          nrec;
      commitRec_t [2:0]    rec;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              done;
   logic              mismatch;
   logic              overflow;
   logic [CNT_W-1:0]  rec_count;
   logic [CNT_W-1:0]  err_index;
   logic [REC_W-1:0]  err_exp;
   logic [REC_W-1:0]  err_act;

   int                passCnt  = 0;
   int                totalCnt = 0;
   commitRec_t        sbQ[$];
   logic [CNT_W-1:0]  modelCount;
   vec_t              tbl [6];
   vec_t              vIdle;
   commitRec_t        junk;

   commit_trace_checker_if bus ();

   commit_trace_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .done      (done),
      .mismatch  (mismatch),
      .overflow  (overflow),
      .rec_count (rec_count),
      .err_index (err_index),
      .err_exp   (err_exp),
      .err_act   (err_act)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic vec_t vReg(input logic [2:0] r, input logic [15:0] d);
      vec_t v = '0;
      v.regW   = 1'b1;
      v.wreg   = r;
      v.wdata  = d;
      v.nrec   = 2'd1;
      v.rec[0] = mkRec(REC_REG, {13'b0, r}, d);
      return v;
   endfunction

   function automatic vec_t vRegSt(input logic [2:0] r, input logic [15:0] d,
                                   input logic [15:0] a, input logic [15:0] s);
      vec_t v = vReg(r, d);
      v.memW   = 1'b1;
      v.addr   = a;
      v.din    = s;
      v.nrec   = 2'd2;
      v.rec[1] = mkRec(REC_STORE, a, s);
      return v;
   endfunction

   task automatic clearIn();
      bus.reg_write = 1'b0; bus.write_reg = '0; bus.write_data = '0;
      bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_addr = '0;
      bus.mem_data_in = '0; bus.mem_data_out = '0; bus.halt = 1'b0;
      bus.exp_valid = 1'b0; bus.exp_type = '0; bus.exp_a = '0; bus.exp_b = '0;
   endtask

   task automatic pushRecs(input vec_t v);
      for (int k = 0; k < int'(v.nrec); k++) sbQ.push_back(v.rec[k]);
   endtask

   // One clock: drive commit v and optionally offer record r, then advance.
   task automatic cycle(input vec_t v, input logic offerEn, input commitRec_t r,
                        input logic readyExp, input string name);
      bus.reg_write = v.regW; bus.write_reg = v.wreg; bus.write_data = v.wdata;
      bus.mem_write = v.memW; bus.mem_read = v.memR; bus.mem_addr = v.addr;
      bus.mem_data_in = v.din; bus.mem_data_out = v.dout; bus.halt = v.hlt;
      bus.exp_valid = offerEn; bus.exp_type = r.recType;
      bus.exp_a = r.fieldA; bus.exp_b = r.fieldB;
      #1;
      if (offerEn) check(name, 64'(bus.exp_ready), 64'(readyExp));
      @(posedge clk);
      #1;
      clearIn();
   endtask

   task automatic drain();
      commitRec_t r;
      while (sbQ.size() > 0) begin
         r = sbQ.pop_front();
         cycle(vIdle, 1'b1, r, 1'b1, "exp_ready");
         modelCount++;
         check("rec_count", 64'(rec_count), 64'(modelCount));
         check("mismatch", 64'(mismatch), 64'd0);
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      clearIn();
      @(posedge clk);
      #1;
      rst = 1'b0;
      sbQ.delete();
      modelCount = '0;
   endtask

   initial begin
      commitRec_t r;
      vec_t v;
      clearIn();
      vIdle = '0;
      junk  = mkRec(REC_HALT, 16'hDEAD, 16'hBEEF);
      modelCount = '0;

      tbl[0] = vReg(3'd3, 16'h1234);
      tbl[1] = '0;
      tbl[1].memW = 1'b1; tbl[1].addr = 16'h0040; tbl[1].din = 16'h5555;
      tbl[1].nrec = 2'd1; tbl[1].rec[0] = mkRec(REC_STORE, 16'h0040, 16'h5555);
      tbl[2] = vRegSt(3'd7, 16'hFFFF, 16'h00FE, 16'h0001);
      tbl[3] = '0;
      tbl[3].memW = 1'b1; tbl[3].memR = 1'b1; tbl[3].addr = 16'h0100;
      tbl[3].din = 16'hA5A5; tbl[3].dout = 16'h1111;
      tbl[3].nrec = 2'd1; tbl[3].rec[0] = mkRec(REC_STORE, 16'h0100, 16'hA5A5);
      tbl[4] = vReg(3'd0, 16'h0000);
      tbl[5] = '0;

      #1;
      doReset();
      check("reset done", 64'(done), 64'd0);
      check("reset mismatch", 64'(mismatch), 64'd0);
      check("reset overflow", 64'(overflow), 64'd0);
      check("reset rec_count", 64'(rec_count), 64'd0);
      check("reset err_exp", 64'(err_exp), 64'd0);

      // Table: one commit cycle, then its records are offered back.
      for (int i = 0; i < 6; i++) begin
         pushRecs(tbl[i]);
         cycle(tbl[i], 1'b1, junk, 1'b0, "same-cycle exp_ready");
         if (tbl[i].nrec == 2'd0) cycle(vIdle, 1'b1, junk, 1'b0, "no-record exp_ready");
         drain();
      end

      // Three records in one cycle ending with HALT; later commits ignored.
      doReset();
      v = vRegSt(3'd1, 16'h00AA, 16'h0040, 16'h5555);
      v.hlt = 1'b1; v.nrec = 2'd3; v.rec[2] = mkRec(REC_HALT, 16'h0, 16'h0);
      pushRecs(v);
      cycle(v, 1'b1, junk, 1'b0, "halt latency");
      r = sbQ.pop_front();
      cycle(vReg(3'd2, 16'h9999), 1'b1, r, 1'b1, "halt first");
      modelCount++;
      drain();
      check("done", 64'(done), 64'd1);
      check("done rec_count", 64'(rec_count), 64'd3);
      cycle(vIdle, 1'b1, junk, 1'b0, "ready after done");
      check("done mismatch", 64'(mismatch), 64'd0);

      // Data mismatch on the fifth record.
      doReset();
      for (int i = 0; i < 2; i++) begin
         v = vRegSt(3'(i + 4), 16'(i * 16'h0111), 16'(16'h0080 + i), 16'(16'h1000 + i));
         pushRecs(v);
         cycle(v, 1'b0, junk, 1'b0, "");
      end
      drain();
      v = '0;
      v.memW = 1'b1; v.addr = 16'h0200; v.din = 16'hBEEE;
      cycle(v, 1'b0, junk, 1'b0, "");
      cycle(vIdle, 1'b1, mkRec(REC_STORE, 16'h0200, 16'hBEEF), 1'b1, "mm ready");
      check("mm mismatch", 64'(mismatch), 64'd1);
      check("mm err_index", 64'(err_index), 64'd4);
      check("mm err_exp", 64'(err_exp), 64'(mkRec(REC_STORE, 16'h0200, 16'hBEEF)));
      check("mm err_act", 64'(err_act), 64'(mkRec(REC_STORE, 16'h0200, 16'hBEEE)));
      check("mm rec_count", 64'(rec_count), 64'd4);
      check("mm done", 64'(done), 64'd0);
      cycle(vReg(3'd1, 16'h0001), 1'b0, junk, 1'b0, "");
      cycle(vIdle, 1'b1, mkRec(REC_REG, 16'h1, 16'h1), 1'b0, "ready after mm");

      // Overflow: fill to DEPTH, push+pop at full, then overflow with a compare.
      doReset();
      for (int i = 0; i < 4; i++) begin
         v = vRegSt(3'(i), 16'(16'h0A00 + i), 16'(16'h0300 + i), 16'(16'h0B00 + i));
         pushRecs(v);
         cycle(v, 1'b0, junk, 1'b0, "");
         check("fill overflow", 64'(overflow), 64'd0);
      end
      r = sbQ.pop_front();
      v = vReg(3'd5, 16'h0505);
      pushRecs(v);
      cycle(v, 1'b1, r, 1'b1, "full pop ready");
      check("full push+pop overflow", 64'(overflow), 64'd0);
      check("full push+pop rec_count", 64'(rec_count), 64'd1);
      r = sbQ.pop_front();
      cycle(vRegSt(3'd6, 16'h0606, 16'h0310, 16'h0C00), 1'b1, r, 1'b1, "ovf pop ready");
      check("ovf overflow", 64'(overflow), 64'd1);
      check("ovf rec_count", 64'(rec_count), 64'd2);
      check("ovf mismatch", 64'(mismatch), 64'd0);
      r = sbQ.pop_front();
      cycle(vIdle, 1'b1, r, 1'b0, "ready after ovf");
      check("ovf sticky", 64'(overflow), 64'd1);

      // Asynchronous reset mid-run with records queued.
      doReset();
      for (int i = 0; i < 3; i++) begin
         v = vRegSt(3'(i + 1), 16'(16'h0101 * (i + 1)), 16'(16'h0011 + i), 16'(16'h2222 + i));
         pushRecs(v);
         cycle(v, 1'b0, junk, 1'b0, "");
      end
      r = sbQ.pop_front();
      cycle(vIdle, 1'b1, r, 1'b1, "pre-rst ready");
      r = sbQ.pop_front();
      r.fieldB = r.fieldB ^ 16'h0001;
      cycle(vIdle, 1'b1, r, 1'b1, "pre-rst bad ready");
      check("pre-rst mismatch", 64'(mismatch), 64'd1);
      #2;
      rst = 1'b1;
      bus.exp_valid = 1'b1;
      #1;
      check("async rst mismatch", 64'(mismatch), 64'd0);
      check("async rst rec_count", 64'(rec_count), 64'd0);
      check("async rst err_act", 64'(err_act), 64'd0);
      check("async rst exp_ready", 64'(bus.exp_ready), 64'd0);
      #1;
      rst = 1'b0;
      clearIn();
      sbQ.delete();
      modelCount = '0;
      v = vReg(3'd6, 16'h0606);
      pushRecs(v);
      cycle(v, 1'b0, junk, 1'b0, "");
      drain();
      check("post-rst err_index", 64'(err_index), 64'd0);

      // Load handling.
      doReset();
      v = '0;
      v.memR = 1'b1; v.addr = 16'h0010; v.dout = 16'h7777;
`ifdef COMMIT_CHK_LOAD_EN
      v.nrec = 2'd1; v.rec[0] = mkRec(REC_LOAD, 16'h0010, 16'h7777);
      pushRecs(v);
      cycle(v, 1'b0, junk, 1'b0, "");
      drain();
`else
      cycle(v, 1'b0, junk, 1'b0, "");
      cycle(vReg(3'd2, 16'h2222), 1'b1, junk, 1'b0, "load no record");
      cycle(vIdle, 1'b1, mkRec(REC_LOAD, 16'h0010, 16'h7777), 1'b1, "load ready");
      check("load mismatch", 64'(mismatch), 64'd1);
      check("load err_index", 64'(err_index), 64'd0);
      check("load err_act", 64'(err_act), 64'(mkRec(REC_REG, 16'h0002, 16'h2222)));
`endif

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
